fifo_serializer: RTL and testbench
==================================

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter DATA_W, default 4, width of the FIFO word being serialized.
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit, minimum 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 en  input  1  high = permitted to pop new words from the FIFO.
REQ-006 fifo_empty  input  1  FIFO empty flag from the upstream fifo_sync.
REQ-007 fifo_data  input  DATA_W  FIFO data_out; valid the cycle after a fifo_rd pulse.
REQ-008 fifo_rd  output  1  read strobe to the FIFO; one cycle per word.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  high while a frame is loading or transmitting.
REQ-011 frame_done  output  1  one-cycle pulse on the final cycle of the stop bit.

Function
REQ-012 The FSM SHALL use states IDLE, LOAD, START, DATA, PARITY (only when PARITY_EN is defined) and STOP.
REQ-013 fifo_rd SHALL equal (state==IDLE) && en && !fifo_empty && !reset, and SHALL never assert while fifo_empty is high.
REQ-014 IDLE -> LOAD SHALL occur on the edge where fifo_rd is high; otherwise the FSM remains in IDLE.
REQ-015 In LOAD (exactly 1 cycle) the block SHALL capture fifo_data into the shift register, then enter START.
REQ-016 START, each DATA bit, PARITY and STOP SHALL each drive tx for exactly CLKS_PER_BIT cycles.
REQ-017 tx SHALL be 0 in START, shift-register bit 0 in DATA (LSB first, DATA_W bits), and 1 in STOP, IDLE and LOAD.
REQ-018 A bit counter SHALL select DATA bits 0..DATA_W-1; DATA exits after bit DATA_W-1 to PARITY or STOP.
REQ-019 After the last STOP cycle the FSM SHALL return to IDLE; frame_done SHALL pulse high in that last STOP cycle only.
REQ-020 Back-to-back words SHALL be separated by exactly 2 tx-high cycles (IDLE + LOAD) after STOP.
REQ-021 busy SHALL be high in every state except IDLE.
REQ-022 en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-023 fifo_empty or fifo_data changes after LOAD SHALL NOT affect the frame in progress.
REQ-024 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT cycles with PARITY_EN.

Reset
REQ-025 Reset SHALL force state IDLE, tx=1, busy=0, frame_done=0, fifo_rd=0, and zero all counters and the shift register.
REQ-026 Reset asserted mid-frame SHALL abort it: tx=1 from the next cycle, no frame_done, and the popped word discarded.
REQ-027 After reset deasserts, a pop SHALL occur in the first cycle in which en=1 and fifo_empty=0.

Configuration
REQ-028 Macro FIFO_SERIALIZER_PARITY_EN defined: a PARITY state SHALL follow DATA, driving tx = XOR of the captured word (even parity).
REQ-029 Macro undefined: no PARITY state or logic SHALL exist, and DATA SHALL go directly to STOP.

Verification (DATA_W=4, CLKS_PER_BIT=4)
REQ-030 Reset held 3 cycles with fifo_empty=0 and en=1 -> tx=1, busy=0, fifo_rd=0, frame_done=0 throughout.
REQ-031 Single word 5 (4'b0101) -> one fifo_rd pulse; tx = 0,1,0,1,0,1, each held 4 cycles; frame_done pulses once; with parity the sequence is 0,1,0,1,0,0,1.
REQ-032 fifo_empty=1 and en=1 for 50 cycles -> fifo_rd never asserts and tx stays 1.
REQ-033 FIFO holds 1,2,3 -> three frames in order with data nibbles 1000, 0100 and 1100 (LSB first), each separated by exactly 2 idle-high cycles.
REQ-034 Reset pulsed during DATA bit 2 of word 7 -> tx=1 on the next cycle, no frame_done; the next word then transmits normally.
REQ-035 en dropped during START of word 6 -> the frame completes with frame_done; no further fifo_rd while en=0.

Source files
------------

// File: rtl/fifo_serializer.sv
// Pops words from an upstream FIFO and sends each as a UART-style frame: start, DATA_W bits LSB first, stop.
// Define FIFO_SERIALIZER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_serializer #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
`ifdef FIFO_SERIALIZER_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bit_end;
`ifdef FIFO_SERIALIZER_PARITY_EN
   logic              parity_q, parity_d;
`endif

   // Combinational so the FIFO sees the strobe in the same cycle IDLE decides to pop.
   assign fifo_rd = (state_q == IDLE) && en && !fifo_empty && !reset;

   assign bit_end = (clk_cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every value written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
`ifdef FIFO_SERIALIZER_PARITY_EN
      parity_d  = parity_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (fifo_rd) begin
               state_d   = LOAD;
               clk_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end
         LOAD: begin
            shift_d   = fifo_data;
`ifdef FIFO_SERIALIZER_PARITY_EN
            parity_d  = ^fifo_data;
`endif
            clk_cnt_d = '0;
            state_d   = START;
         end
         START: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (bit_cnt_q == BIT_LAST) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_ONE;
                  shift_d   = shift_q >> 1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_ONE;
            end
         end
`ifdef FIFO_SERIALIZER_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_ONE;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies line up with state_q.
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef FIFO_SERIALIZER_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (clk_cnt_d == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef FIFO_SERIALIZER_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef FIFO_SERIALIZER_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench for fifo_serializer: a queue-backed FIFO model and frames predicted from word values.
// Honours FIFO_SERIALIZER_PARITY_EN the same way the design does.
module tb_fifo_serializer;

   localparam int DATA_W = 4;
   localparam int CPB    = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              en = 1'b0;
   logic              fifo_empty = 1'b1;
   logic [DATA_W-1:0] fifo_data = '0;
   logic              fifo_rd;
   logic              tx;
   logic              busy;
   logic              frame_done;

   int errors = 0;
   int checks = 0;
   int q[$];
   bit scramble = 1'b0;

   fifo_serializer #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Upstream FIFO: data appears the cycle after the read strobe; the empty flag follows the queue.
   always @(posedge clk) begin
      if (fifo_rd) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL underflow: fifo_rd=1 while the FIFO is empty");
         end else begin
            fifo_data <= DATA_W'(q.pop_front());
         end
      end else if (scramble) begin
         fifo_data <= DATA_W'($urandom);
      end
      fifo_empty <= (q.size() == 0);
   end

   task automatic wait_rd(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         #1;
         if (fifo_rd === 1'b1) return;
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL %s: fifo_rd never asserted within %0d cycles", name, budget);
   endtask

   // Entered at the IDLE cycle where the pop happens; returns at the following IDLE cycle.
   task automatic check_frame(input logic [DATA_W-1:0] w, input bit drop_en, input string name);
      int  bits[$];
      logic exp_tx, exp_done;
      bits.push_back(0);
      for (int i = 0; i < DATA_W; i++) bits.push_back((int'(w) >> i) & 1);
`ifdef FIFO_SERIALIZER_PARITY_EN
      bits.push_back(int'(^w));
`endif
      bits.push_back(1);

      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b1 || fifo_rd !== 1'b0)
         begin errors++; $display("FAIL %s load: tx=%b busy=%b rd=%b, want 1 1 0", name, tx, busy, fifo_rd); end

      for (int k = 0; k < bits.size(); k++) begin
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (drop_en && k == 0 && c == 0) begin
               en = 1'b0;
               scramble = 1'b1;
            end
            exp_tx   = (bits[k] != 0);
            exp_done = (k == bits.size() - 1) && (c == CPB - 1);
            checks++;
            if (tx !== exp_tx)
               begin errors++; $display("FAIL %s tx bit%0d cyc%0d: got %b want %b", name, k, c, tx, exp_tx); end
            checks++;
            if (frame_done !== exp_done || busy !== 1'b1 || fifo_rd !== 1'b0)
               begin errors++; $display("FAIL %s ctl bit%0d cyc%0d: done=%b busy=%b rd=%b, want %b 1 0",
                                        name, k, c, frame_done, busy, fifo_rd, exp_done); end
         end
      end

      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0)
         begin errors++; $display("FAIL %s idle: tx=%b busy=%b done=%b, want 1 0 0", name, tx, busy, frame_done); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en    = 1'b1;
      q.push_back(4'hA);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 || frame_done !== 1'b0)
            begin errors++; $display("FAIL reset_hold: tx=%b busy=%b rd=%b done=%b, want 1 0 0 0",
                                     tx, busy, fifo_rd, frame_done); end
      end
      reset = 1'b0;
      #1;
      checks++;
      if (fifo_rd !== 1'b1)
         begin errors++; $display("FAIL reset_first_pop: rd=%b want 1", fifo_rd); end
      check_frame(4'hA, 1'b0, "reset_frame");
   endtask

   task automatic test_single();
      q.push_back(5);
      wait_rd(20, "single_rd");
      check_frame(4'd5, 1'b0, "single");
   endtask

   task automatic test_empty();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (fifo_rd !== 1'b0 || tx !== 1'b1)
            begin errors++; $display("FAIL empty cyc%0d: rd=%b tx=%b, want 0 1", i, fifo_rd, tx); end
      end
   endtask

   task automatic run_burst(input int words[$], input string name);
      foreach (words[i]) q.push_back(words[i]);
      wait_rd(20, name);
      foreach (words[i]) begin
         check_frame(DATA_W'(words[i]), 1'b0, name);
         #1;
         checks++;
         if (i < words.size() - 1) begin
            if (fifo_rd !== 1'b1)
               begin errors++; $display("FAIL %s gap%0d: rd=%b want 1", name, i, fifo_rd); end
         end else if (fifo_rd !== 1'b0) begin
            errors++; $display("FAIL %s drained: rd=%b want 0", name, fifo_rd);
         end
      end
   endtask

   task automatic test_back_to_back();
      int words[$];
      words = '{1, 2, 3};
      run_burst(words, "b2b");
   endtask

   task automatic test_reset_mid();
      q.push_back(7);
      q.push_back(9);
      wait_rd(20, "rmid_rd");
      repeat (1 + CPB + 2 * CPB + 1) @(negedge clk);
      checks++;
      if (tx !== 1'b1)
         begin errors++; $display("FAIL rmid_bit2: tx=%b want 1", tx); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || fifo_rd !== 1'b0)
         begin errors++; $display("FAIL rmid_abort: tx=%b busy=%b done=%b rd=%b, want 1 0 0 0",
                                  tx, busy, frame_done, fifo_rd); end
      reset = 1'b0;
      #1;
      checks++;
      if (fifo_rd !== 1'b1)
         begin errors++; $display("FAIL rmid_repop: rd=%b want 1", fifo_rd); end
      check_frame(4'd9, 1'b0, "rmid_next");
   endtask

   task automatic test_en_drop();
      q.push_back(6);
      q.push_back(3);
      wait_rd(20, "endrop_rd");
      check_frame(4'd6, 1'b1, "endrop");
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++;
         if (fifo_rd !== 1'b0 || tx !== 1'b1)
            begin errors++; $display("FAIL endrop_hold cyc%0d: rd=%b tx=%b, want 0 1", i, fifo_rd, tx); end
         @(negedge clk);
      end
      scramble = 1'b0;
      en = 1'b1;
      wait_rd(5, "endrop_resume");
      check_frame(4'd3, 1'b0, "endrop_next");
   endtask

   task automatic test_random();
      int words[$];
      for (int i = 0; i < 6; i++) words.push_back(int'($urandom_range(0, (1 << DATA_W) - 1)));
      run_burst(words, "random");
   endtask

   initial begin
      test_reset();
      test_single();
      test_empty();
      test_back_to_back();
      test_reset_mid();
      test_en_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
